// File: rtl/d16_bus_fabric_if.sv
// d16_bus_fabric_if: cpu bus, slave fan-out and irq lines of the d16 bus fabric
interface d16_bus_fabric_if #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int NSLV = 2,
  parameter int SELW = 4
);
  logic                 i_wb_cyc;
  logic                 i_wb_we;
  logic [AW-1:0]        i_wb_addr;
  logic [DW-1:0]        i_wb_dat;
  logic [DW-1:0]        o_wb_dat;
  logic                 o_wb_ack;
  logic                 o_wb_err;
  logic [NSLV-1:0]      o_s_cyc;
  logic                 o_s_we;
  logic [AW-SELW-1:0]   o_s_addr;
  logic [DW-1:0]        o_s_dat;
  logic [NSLV*DW-1:0]   i_s_dat;
  logic [NSLV-1:0]      i_s_ack;
  logic [NSLV-1:0]      i_irq;
  logic                 o_int;
  modport slave (
    input  i_wb_cyc, i_wb_we, i_wb_addr, i_wb_dat, i_s_dat, i_s_ack, i_irq,
    output o_wb_dat, o_wb_ack, o_wb_err, o_s_cyc, o_s_we, o_s_addr, o_s_dat, o_int
  );
  modport master (
    output i_wb_cyc, i_wb_we, i_wb_addr, i_wb_dat, i_s_dat, i_s_ack, i_irq,
    input  o_wb_dat, o_wb_ack, o_wb_err, o_s_cyc, o_s_we, o_s_addr, o_s_dat, o_int
  );
endinterface

// File: rtl/d16_bus_fabric.sv
// d16_bus_fabric: single-master decoder with registered slave responses, timeout errors and irq aggregation
module d16_bus_fabric #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int NSLV = 2,
  parameter int SELW = 4,
  parameter int TIMEOUT = 15
) (
  input logic i_clk,
  input logic i_reset,
  d16_bus_fabric_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
  localparam int OW = AW - SELW;
  localparam logic [SELW-1:0] NS = SELW'(NSLV);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic we_q, we_d, ack_q, ack_d, err_q, err_d, int_q;
  logic [OW-1:0] off_q, off_d;
  logic [DW-1:0] sdat_q, sdat_d, rdat_q, rdat_d, reg_rd, slv_rd;
  logic [NSLV-1:0] cyc_q, cyc_d, pend_q, mask_q, mask_d, irq_q, clr;
  logic [SELW-1:0] idx;
  logic is_slv, is_reg, slv_ack;
  assign idx = bus.i_wb_addr[AW-1 -: SELW];
  assign is_slv = idx < NS;
  assign is_reg = &idx;
  // cyc_q is one-hot on the selected slave, so it masks out foreign acks
  assign slv_ack = |(bus.i_s_ack & cyc_q);
  assign reg_rd = bus.i_wb_addr[1:0] == 2'd0 ? DW'(pend_q) :
                  bus.i_wb_addr[1:0] == 2'd1 ? DW'(mask_q) :
                  bus.i_wb_addr[1:0] == 2'd2 ? DW'(bus.i_irq) : '0;
  always_comb begin
    slv_rd = '0;
    for (int k = 0; k < NSLV; k++) if (cyc_q[k]) slv_rd = bus.i_s_dat[k*DW +: DW];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    off_d = off_q;
    sdat_d = sdat_q;
    cyc_d = cyc_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    rdat_d = rdat_q;
    clr = '0;
    mask_d = mask_q;
    case (state_q)
      IDLE: if (bus.i_wb_cyc) begin
        we_d = bus.i_wb_we;
        off_d = bus.i_wb_addr[OW-1:0];
        sdat_d = bus.i_wb_dat;
        if (is_slv) begin
          state_d = BUSY;
          cnt_d = '0;
          cyc_d = NSLV'(1) << idx;
        end else begin
          state_d = RESP;
          ack_d = is_reg;
          err_d = !is_reg;
          rdat_d = !is_reg ? '1 : bus.i_wb_we ? '0 : reg_rd;
          if (is_reg && bus.i_wb_we) begin
            clr = bus.i_wb_addr[1:0] == 2'd0 ? bus.i_wb_dat[NSLV-1:0] : '0;
            mask_d = bus.i_wb_addr[1:0] == 2'd1 ? bus.i_wb_dat[NSLV-1:0] : mask_q;
          end
        end
      end
      BUSY: if (slv_ack || cnt_q == TLAST) begin
        state_d = RESP;
        cyc_d = '0;
        ack_d = slv_ack;
        err_d = !slv_ack;
        rdat_d = !slv_ack ? '1 : we_q ? '0 : slv_rd;
      end else cnt_d = cnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      off_q <= '0;
      sdat_q <= '0;
      cyc_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rdat_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      irq_q <= '0;
      int_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      off_q <= off_d;
      sdat_q <= sdat_d;
      cyc_q <= cyc_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rdat_q <= rdat_d;
      pend_q <= (pend_q & ~clr) | (bus.i_irq & ~irq_q);
      mask_q <= mask_d;
      irq_q <= bus.i_irq;
      int_q <= |(pend_q & mask_q);
    end
  assign bus.o_wb_dat = rdat_q;
  assign bus.o_wb_ack = ack_q;
  assign bus.o_wb_err = err_q;
  assign bus.o_s_cyc = cyc_q;
  assign bus.o_s_we = we_q;
  assign bus.o_s_addr = off_q;
  assign bus.o_s_dat = sdat_q;
  assign bus.o_int = int_q;
endmodule

// File: tb/tb_d16_bus_fabric.sv
// tb_d16_bus_fabric: random and directed bus traffic checked against a transaction-timing model
module tb_d16_bus_fabric;
  localparam int TO = 15;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  d16_bus_fabric_if #(.DW(16), .AW(16), .NSLV(2), .SELW(4)) bus();
  d16_bus_fabric #(.DW(16), .AW(16), .NSLV(2), .SELW(4), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus.slave)
  );
  int cmp = 0, bad = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] init_val(input int k, input int i);
    return (k == 1 && i == 4) ? 16'hBEEF : 16'(k * 4951 + i * 1057 + 23130);
  endfunction
  logic [15:0] smem [2][16];
  int scnt [2];
  int dly [2];
  logic [1:0] noise = 2'b0, irq_rnd = 2'b0, irq_dir = 2'b0;
  bit rnd_irq = 0;
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      scnt[k] <= bus.o_s_cyc[k] ? scnt[k] + 1 : 0;
      if (rst) for (int i = 0; i < 16; i++) smem[k][i] <= init_val(k, i);
      else if (bus.o_s_cyc[k] && bus.i_s_ack[k] && bus.o_s_we) smem[k][bus.o_s_addr[3:0]] <= bus.o_s_dat;
    end
  assign bus.i_s_ack = {bus.o_s_cyc[1] ? scnt[1] == dly[1] : noise[1],
                        bus.o_s_cyc[0] ? scnt[0] == dly[0] : noise[0]};
  assign bus.i_s_dat = {smem[1][bus.o_s_addr[3:0]], smem[0][bus.o_s_addr[3:0]]};
  assign bus.i_irq = rnd_irq ? irq_rnd : irq_dir;
  always @(negedge clk) begin
    noise = 2'($urandom);
    if ($urandom_range(0, 3) == 0) irq_rnd = irq_rnd ^ 2'($urandom);
  end
  // Model: each accepted transfer has a response edge ta+tl; everything else follows from timing
  logic [15:0] mm [2][16];
  int n = 0, nxt = 0, ta = 0, tl = 0, tslv = -1;
  bit tv = 0, terr = 0, started = 0, rst_seen = 0;
  logic [15:0] tdat = '0, e_sdat = '0, e_dat = '0;
  logic [1:0] pend = '0, mask = '0, prev = '0, e_scyc = '0;
  logic [11:0] e_sadr = '0;
  logic e_ack = 0, e_err = 0, e_int = 0, e_swe = 0;
  always @(posedge clk) begin
    logic int_n;
    logic [1:0] clr, mnew;
    int idx;
    n++;
    started = 1;
    rst_seen = rst;
    if (rst) begin
      pend = '0; mask = '0; prev = '0; e_int = 0; tv = 0; nxt = n + 1;
      e_swe = 0; e_sadr = '0; e_sdat = '0; e_dat = '0;
      for (int k = 0; k < 2; k++) for (int i = 0; i < 16; i++) mm[k][i] = init_val(k, i);
    end else begin
      int_n = |(pend & mask);
      clr = '0;
      mnew = mask;
      if (bus.i_wb_cyc && n >= nxt) begin
        idx = int'(bus.i_wb_addr[15:12]);
        ta = n; tv = 1; tslv = -1;
        e_swe = bus.i_wb_we; e_sadr = bus.i_wb_addr[11:0]; e_sdat = bus.i_wb_dat;
        if (idx < 2) begin
          tslv = idx;
          if (dly[idx] < TO) begin
            tl = 1 + dly[idx]; terr = 0;
            tdat = bus.i_wb_we ? 16'h0 : mm[idx][bus.i_wb_addr[3:0]];
            if (bus.i_wb_we) mm[idx][bus.i_wb_addr[3:0]] = bus.i_wb_dat;
          end else begin
            tl = TO; terr = 1; tdat = 16'hFFFF;
          end
        end else if (idx == 15) begin
          tl = 0; terr = 0;
          case (bus.i_wb_addr[1:0])
            2'd0: tdat = {14'h0, pend};
            2'd1: tdat = {14'h0, mask};
            2'd2: tdat = {14'h0, bus.i_irq};
            default: tdat = 16'h0;
          endcase
          if (bus.i_wb_we) begin
            tdat = 16'h0;
            if (bus.i_wb_addr[1:0] == 2'd0) clr = bus.i_wb_dat[1:0];
            if (bus.i_wb_addr[1:0] == 2'd1) mnew = bus.i_wb_dat[1:0];
          end
        end else begin
          tl = 0; terr = 1; tdat = 16'hFFFF;
        end
        nxt = n + tl + 2;
      end
      pend = (pend & ~clr) | (bus.i_irq & ~prev);
      prev = bus.i_irq;
      mask = mnew;
      e_int = int_n;
    end
    e_scyc = (tv && tslv >= 0 && n >= ta && n < ta + tl) ? 2'(1 << tslv) : 2'b0;
    e_ack = tv && n == ta + tl && !terr;
    e_err = tv && n == ta + tl && terr;
    if (e_ack || e_err) e_dat = tdat;
  end
  always @(negedge clk)
    if (started) begin
      check("wb_ack", 32'(bus.o_wb_ack), 32'(e_ack));
      check("wb_err", 32'(bus.o_wb_err), 32'(e_err));
      check("s_cyc", 32'(bus.o_s_cyc), 32'(e_scyc));
      check("s_we", 32'(bus.o_s_we), 32'(e_swe));
      check("s_addr", 32'(bus.o_s_addr), 32'(e_sadr));
      check("s_dat", 32'(bus.o_s_dat), 32'(e_sdat));
      check("int", 32'(bus.o_int), 32'(e_int));
      if (e_ack || e_err || rst_seen) check("wb_dat", 32'(bus.o_wb_dat), 32'(e_dat));
    end
  logic r_ack, r_err, r_int, r_int2, r_swe;
  logic [15:0] r_dat, r_sdat;
  logic [11:0] r_sadr;
  int r_lat, r_scyc;
  task automatic txn(input logic [15:0] a, input logic we, input logic [15:0] d);
    bit done = 0;
    bus.i_wb_cyc = 1'b1; bus.i_wb_addr = a; bus.i_wb_we = we; bus.i_wb_dat = d;
    r_lat = 0; r_scyc = 0; r_ack = 0; r_err = 0; r_dat = '0; r_int = 0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      bus.i_wb_cyc = 1'b0;
      if (bus.o_s_cyc != 2'b0) begin
        r_scyc++; r_sadr = bus.o_s_addr; r_swe = bus.o_s_we; r_sdat = bus.o_s_dat;
      end
      if (bus.o_wb_ack || bus.o_wb_err) begin
        done = 1; r_lat = i; r_ack = bus.o_wb_ack; r_err = bus.o_wb_err;
        r_dat = bus.o_wb_dat; r_int = bus.o_int;
      end
    end
    check("txn_done", 32'(done), 32'd1);
    @(negedge clk);
    r_int2 = bus.o_int;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.i_wb_cyc = 1'b0; bus.i_wb_we = 1'b0; bus.i_wb_addr = '0; bus.i_wb_dat = '0;
    dly[0] = 0; dly[1] = 0;
    repeat (2) @(negedge clk);
    check("rst_scyc", 32'(bus.o_s_cyc), 32'd0);
    check("rst_ackerr", 32'({bus.o_wb_ack, bus.o_wb_err}), 32'd0);
    check("rst_dat", 32'(bus.o_wb_dat), 32'd0);
    rst = 1'b0;
    dly[1] = 3;
    txn(16'h1004, 1'b0, 16'h0);
    check("t1_ack", 32'(r_ack), 32'd1);
    check("t1_dat", 32'(r_dat), 32'hBEEF);
    check("t1_lat", 32'(r_lat), 32'd5);
    check("t1_scyc", 32'(r_scyc), 32'd4);
    check("t1_saddr", 32'(r_sadr), 32'h004);
    dly[0] = 0;
    txn(16'h0010, 1'b1, 16'h1234);
    check("t2_ack", 32'(r_ack), 32'd1);
    check("t2_lat", 32'(r_lat), 32'd2);
    check("t2_swe", 32'(r_swe), 32'd1);
    check("t2_sdat", 32'(r_sdat), 32'h1234);
    txn(16'h7000, 1'b0, 16'h0);
    check("t3_err", 32'(r_err), 32'd1);
    check("t3_lat", 32'(r_lat), 32'd1);
    check("t3_dat", 32'(r_dat), 32'hFFFF);
    check("t3_scyc", 32'(r_scyc), 32'd0);
    dly[0] = 255;
    txn(16'h0000, 1'b0, 16'h0);
    check("t4_err", 32'(r_err), 32'd1);
    check("t4_scyc", 32'(r_scyc), 32'd15);
    check("t4_lat", 32'(r_lat), 32'd16);
    dly[0] = 1;
    txn(16'h0010, 1'b0, 16'h0);
    check("t4_next", 32'(r_dat), 32'h1234);
    check("t4_nlat", 32'(r_lat), 32'd3);
    txn(16'hF001, 1'b1, 16'h0002);
    irq_dir = 2'b10;
    @(negedge clk);
    irq_dir = 2'b00;
    repeat (2) @(negedge clk);
    txn(16'hF000, 1'b0, 16'h0);
    check("t5_pend", 32'(r_dat), 32'h2);
    check("t5_int", 32'(r_int), 32'd1);
    irq_dir = 2'b10;
    txn(16'hFFF0, 1'b1, 16'h0002);
    irq_dir = 2'b00;
    txn(16'hF000, 1'b0, 16'h0);
    check("t5_setwins", 32'(r_dat), 32'h2);
    txn(16'hF000, 1'b1, 16'h0002);
    check("t5_int_hold", 32'(r_int), 32'd1);
    check("t5_int_drop", 32'(r_int2), 32'd0);
    irq_dir = 2'b01;
    txn(16'hF002, 1'b0, 16'h0);
    check("t5_raw", 32'(r_dat), 32'h1);
    irq_dir = 2'b00;
    dly[1] = 255;
    bus.i_wb_cyc = 1'b1; bus.i_wb_addr = 16'h1000; bus.i_wb_we = 1'b0;
    @(negedge clk);
    bus.i_wb_cyc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_scyc", 32'(bus.o_s_cyc), 32'd0);
    check("t6_ackerr", 32'({bus.o_wb_ack, bus.o_wb_err}), 32'd0);
    dly[1] = 2;
    txn(16'h1004, 1'b0, 16'h0);
    check("t6_read", 32'(r_dat), 32'hBEEF);
    check("t6_lat", 32'(r_lat), 32'd4);
    rnd_irq = 1;
    repeat (200) begin
      int r;
      logic [3:0] idx;
      r = $urandom_range(0, 7);
      idx = r < 3 ? 4'd0 : r < 5 ? 4'd1 : r < 7 ? 4'd15 : 4'($urandom_range(2, 14));
      for (int k = 0; k < 2; k++) dly[k] = $urandom_range(0, 9) == 0 ? 20 : $urandom_range(0, 5);
      txn({idx, 12'($urandom)}, 1'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
